uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_50 cycles per UART bit (50 MHz / 115200 baud); legal range 16..65535.
REQ-002 The block SHALL have port clk_50  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_board  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port rx_line  input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 The block SHALL have port rx_valid  output  1  holding register contains an unconsumed byte.
REQ-007 The block SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 The block SHALL have port overrun  output  1  one-cycle pulse: byte completed while holding register full and not drained.

Function
REQ-010 rx_line SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value (rx_s).
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; reset state IDLE.
REQ-012 IDLE: a falling edge of rx_s (previous 1, current 0) SHALL clear the bit counter and enter START; a steady-low rx_s SHALL NOT start a frame.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division), rx_s SHALL be sampled; 0 -> DATA with bit index 0, counter cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-014 DATA: every CLKS_PER_BIT cycles rx_s SHALL be sampled into bit [index] of a shift register, LSB first; after index 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles rx_s SHALL be sampled; 1 -> byte complete; 0 -> frame_err=1 for exactly one cycle, byte discarded; both -> IDLE.
REQ-016 Bit counter SHALL be 16 bits and SHALL wrap to 0 at each sample point; it never exceeds CLKS_PER_BIT-1.
REQ-017 On byte complete with rx_valid=0, rx_data SHALL load the byte and rx_valid SHALL rise in the next cycle.
REQ-018 Transfer SHALL occur on a cycle with rx_valid=1 and rx_ready=1; rx_valid then clears next cycle unless REQ-019 applies.
REQ-019 Byte complete in the same cycle as a transfer SHALL load the new byte, keep rx_valid=1, and SHALL NOT pulse overrun.
REQ-020 Byte complete with rx_valid=1 and rx_ready=0 SHALL drop the new byte, keep rx_data unchanged, and pulse overrun for one cycle.
REQ-021 rx_data SHALL NOT change while rx_valid=1 except per REQ-019.
REQ-022 Latency from the rx_line falling edge to rx_valid rising SHALL be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, +/-1.
REQ-023 After STOP returns to IDLE, a new start edge SHALL be accepted on the very next cycle, supporting back-to-back frames with one stop bit.
REQ-024 frame_err and overrun SHALL never be asserted in the same cycle as each other.

Reset
REQ-025 While rst_board=0: state IDLE, counters 0, shift register 0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume only at the next falling edge.
REQ-027 Reset release SHALL NOT itself be treated as a start edge, even if rx_line is low.

Verification
REQ-028 Send 0x55 at CLKS_PER_BIT=434, rx_ready=1 -> rx_valid high exactly one cycle with rx_data=0x55 at REQ-022 latency; frame_err=overrun=0.
REQ-029 Send 0xA5 then 0x3C back-to-back, rx_ready=0 -> rx_data=0xA5 held, rx_valid=1, one overrun pulse at 0x3C completion; raise rx_ready -> rx_valid clears next cycle.
REQ-030 Send 0x81 with stop bit forced 0 -> one frame_err pulse, rx_valid stays 0; following 0x7E received correctly.
REQ-031 Low glitch of 100 cycles on idle rx_line -> no rx_valid, frame_err or overrun; FSM back in IDLE within CLKS_PER_BIT/2+3 cycles.
REQ-032 rst_board low during bit 4 of 0xF0 -> all outputs 0 immediately; after release, send 0x0F -> rx_data=0x0F, no error pulses.
REQ-033 Hold rx_valid=1 with 0x11, assert rx_ready exactly in the cycle 0x22 completes -> rx_valid stays 1, rx_data=0x22 next cycle, no overrun.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-deep
// holding register with valid/ready hand-off, frame-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50,
    input  logic       rst_board,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    // Handshake: a byte moves to the consumer on any cycle where rx_valid and
    // rx_ready are both 1; rx_data is stable while rx_valid=1 until then.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic        sync_1, rx_s, rx_prev;
    logic [2:0]  warm;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic        start_edge, tick, byte_done, stop_bad;

    // Edges are only trusted once the synchronizer and rx_prev hold real
    // samples, so a line already low at reset release cannot start a frame.
    always_ff @(posedge clk_50 or negedge rst_board) begin
        if (!rst_board) begin
            sync_1  <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            warm    <= 3'b000;
        end else begin
            sync_1  <= rx_line;
            rx_s    <= sync_1;
            rx_prev <= rx_s;
            warm    <= {warm[1:0], 1'b1};
        end
    end

    assign start_edge = warm[2] & rx_prev & ~rx_s;
    assign tick       = (cnt == ((state_q == START) ? HALF_M1 : FULL_M1));
    assign state_dbg  = state_q;

    always_ff @(posedge clk_50 or negedge rst_board) begin
        if (!rst_board) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE:  if (start_edge) state_d = START;
            START: if (tick) state_d = rx_s ? IDLE : DATA;
            DATA:  if (tick && (bit_idx == 3'd7)) state_d = STOP;
            STOP: begin
                if (tick) begin
                    state_d   = IDLE;
                    byte_done = rx_s;
                    stop_bad  = ~rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_board) begin
        if (!rst_board) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            if ((state_q == IDLE) || tick) cnt <= 16'd0;
            else                           cnt <= cnt + 16'd1;
            if (state_q != DATA)  bit_idx <= 3'd0;
            else if (tick)        bit_idx <= bit_idx + 3'd1;
            if ((state_q == DATA) && tick) shift_q[bit_idx] <= rx_s;
        end
    end

    // A completed byte may replace the held one only when it leaves this cycle.
    always_ff @(posedge clk_50 or negedge rst_board) begin
        if (!rst_board) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err <= stop_bad;
            overrun   <= byte_done & rx_valid & ~rx_ready;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed plus randomized bench for uart_rx, checked against a frame-level
// model of the holding register and a queue of bytes expected at the consumer.
module tb_uart_rx;

    localparam int CPB  = 434;
    localparam int HALF = CPB / 2;
    localparam int NOM  = 2 + HALF + 9 * CPB + 1;

    logic       clk_50 = 1'b0;
    logic       rst_board, rx_line, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [1:0] state_dbg;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50(clk_50), .rst_board(rst_board), .rx_line(rx_line),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .state_dbg(state_dbg)
    );

    always #10 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Observed activity, sampled on the falling edge.
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, rise_cnt = 0, hi_cnt = 0, rise_cyc = 0;
    logic v_prev = 1'b0;
    logic [7:0] got_q[$];
    always @(negedge clk_50) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid && !v_prev) begin rise_cnt++; rise_cyc = cyc; end
        if (rx_valid) hi_cnt++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        v_prev = rx_valid;
    end

    // Reference model and scoreboard.
    int n_assert = 0, n_fail = 0;
    int exp_fe = 0, exp_ov = 0, t_fall = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_set_ready(input logic r);
        @(posedge clk_50); #1;
        rx_ready = r;
        if (r && m_valid) begin exp_q.push_back(m_data); m_valid = 1'b0; end
    endtask

    task automatic m_frame(input logic [7:0] d, input logic stop_v);
        if (!stop_v)          exp_fe++;
        else if (m_valid)     exp_ov++;
        else if (rx_ready)    exp_q.push_back(d);
        else begin m_valid = 1'b1; m_data = d; end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        if (m_valid) check({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_ferr"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_ovr"}, 32'(ov_cnt), 32'(exp_ov));
    endtask

    task automatic sb_drain(input string tag);
        check({tag, "_qsize"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        @(posedge clk_50); #1;
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            if (i == 0) t_fall = cyc;
            repeat (CPB) @(posedge clk_50);
            #1;
        end
        rx_line = 1'b1;
    endtask

    int r0, h0, f0, o0, lat;

    initial begin
        rst_board = 1'b0; rx_line = 1'b1; rx_ready = 1'b0;
        repeat (5) @(posedge clk_50); #1;
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_state", 32'(state_dbg), 0);
        rst_board = 1'b1;
        repeat (5) @(posedge clk_50);

        // Single byte, consumer always ready.
        m_set_ready(1'b1);
        r0 = rise_cnt; h0 = hi_cnt;
        send_frame(8'h55, 1'b1); m_frame(8'h55, 1'b1);
        lat = rise_cyc - t_fall;
        check("b55_rises", 32'(rise_cnt - r0), 1);
        check("b55_hi_cycles", 32'(hi_cnt - h0), 1);
        check("b55_latency_ok", 32'((lat >= NOM - 1) && (lat <= NOM + 1)), 1);
        check_state("b55");
        sb_drain("b55");

        // Back-to-back with consumer stalled: second byte overruns.
        m_set_ready(1'b0);
        send_frame(8'hA5, 1'b1); m_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1); m_frame(8'h3C, 1'b1);
        check_state("ovr");
        m_set_ready(1'b1);
        @(negedge clk_50); check("ovr_valid_xfer", 32'(rx_valid), 1);
        @(negedge clk_50); check("ovr_valid_clear", 32'(rx_valid), 0);
        sb_drain("ovr");

        // Bad stop bit, then a good frame.
        r0 = rise_cnt;
        send_frame(8'h81, 1'b0); m_frame(8'h81, 1'b0);
        check("ferr_no_valid", 32'(rise_cnt - r0), 0);
        check_state("ferr");
        send_frame(8'h7E, 1'b1); m_frame(8'h7E, 1'b1);
        check_state("after_ferr");
        sb_drain("after_ferr");

        // 100-cycle low glitch on an idle line.
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        @(posedge clk_50); #1; rx_line = 1'b0;
        repeat (10) @(posedge clk_50); #1;
        check("glitch_in_start", 32'(state_dbg), 1);
        repeat (90) @(posedge clk_50); #1; rx_line = 1'b1;
        repeat (HALF + 3 - 100) @(posedge clk_50); #1;
        check("glitch_back_idle", 32'(state_dbg), 0);
        repeat (CPB) @(posedge clk_50);
        check("glitch_activity", 32'((rise_cnt - r0) + (fe_cnt - f0) + (ov_cnt - o0)), 0);

        // Consumer takes the held byte in the exact cycle the next completes.
        m_set_ready(1'b0);
        send_frame(8'h11, 1'b1); m_frame(8'h11, 1'b1);
        check_state("hold11");
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait (rx_line === 1'b0);
                repeat (2 + HALF + 9 * CPB) @(posedge clk_50); #1;
                rx_ready = 1'b1;
                @(posedge clk_50); #1;
                rx_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h11); m_data = 8'h22; m_valid = 1'b1;
        check_state("swap22");
        sb_drain("swap22");

        // Reset in the middle of bit 4 while a byte is held.
        r0 = rise_cnt;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait (rx_line === 1'b0);
                repeat (5 * CPB + HALF) @(posedge clk_50); #1;
                rst_board = 1'b0; #1;
                check("midrst_valid", 32'(rx_valid), 0);
                check("midrst_data", 32'(rx_data), 0);
                check("midrst_ferr", 32'(frame_err), 0);
                check("midrst_ovr", 32'(overrun), 0);
                check("midrst_state", 32'(state_dbg), 0);
                repeat (5) @(posedge clk_50); #1;
                rst_board = 1'b1;
            end
        join
        m_valid = 1'b0; m_data = 8'h00;
        repeat (20) @(posedge clk_50); #1;
        check("midrst_no_rise", 32'(rise_cnt - r0), 0);
        check("midrst_idle", 32'(state_dbg), 0);
        check_state("midrst");

        // Release reset with the line held low: no frame may start.
        @(posedge clk_50); #1;
        rst_board = 1'b0; rx_line = 1'b0;
        repeat (4) @(posedge clk_50); #1;
        rst_board = 1'b1;
        repeat (3 * CPB) @(posedge clk_50); #1;
        check("lowrel_idle", 32'(state_dbg), 0);
        check_state("lowrel");
        rx_line = 1'b1;
        repeat (10) @(posedge clk_50);

        m_set_ready(1'b1);
        send_frame(8'h0F, 1'b1); m_frame(8'h0F, 1'b1);
        check_state("b0f");
        sb_drain("b0f");

        // Random bytes, stop bits and consumer readiness.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic       st;
            d  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            m_set_ready(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 20)) @(posedge clk_50);
            send_frame(d, st); m_frame(d, st);
            check_state("rand");
        end
        m_set_ready(1'b1);
        repeat (5) @(posedge clk_50); #1;
        check_state("rand_end");
        sb_drain("rand_end");
        check("ferr_ovr_same_cycle", 32'(both_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
